fetch_sequencer: RTL

- Controller that sequences the program counter and the instruction-memory fetch port for the RISC-V core.
- Owns the PC register and issues one instruction-memory request at a time over a valid/ready handshake.
- Delivers each fetched instruction with its PC to decode, and handles stall from decode and branch/jump redirects from execute, including discarding responses that are in flight when a redirect arrives.

---
 rtl/fetch_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : PC owner and single-outstanding instruction fetch controller.
//            Drops in-flight responses after a redirect.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
  parameter logic [ADDR_W-1:0]  PC_INC    = ADDR_W'(4)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              inst_valid,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] PC
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] r_req_pc;
  logic [ADDR_W-1:0] w_req_pc_nxt;
  logic              r_inst_valid;
  logic              w_inst_valid_nxt;
  logic [31:0]       r_inst_data;
  logic [31:0]       w_inst_data_nxt;
  logic [ADDR_W-1:0] r_inst_pc;
  logic [ADDR_W-1:0] w_inst_pc_nxt;

  logic              w_req_valid;
  logic              w_handshake;
  logic              w_rsp_accept;

  assign w_req_valid  = (r_state == S_FETCH) && !stall && !redirect_valid;
  assign w_handshake  = w_req_valid && imem_req_ready;
  // A redirect in the same cycle as the response puts it on the wrong path.
  assign w_rsp_accept = (r_state == S_WAIT) && imem_rsp_valid && !redirect_valid;

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_req_pc_nxt = r_req_pc;

    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (redirect_valid) begin
          w_pc_nxt = redirect_pc;
        end else if (w_handshake) begin
          w_req_pc_nxt = r_pc;
          w_pc_nxt     = r_pc + PC_INC;
          w_state_nxt  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          w_pc_nxt    = redirect_pc;
          w_state_nxt = imem_rsp_valid ? S_FETCH : S_DRAIN;
        end else if (imem_rsp_valid) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (redirect_valid) begin
          w_pc_nxt = redirect_pc;
        end
        if (imem_rsp_valid) begin
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_inst_valid_nxt = r_inst_valid;
    w_inst_data_nxt  = r_inst_data;
    w_inst_pc_nxt    = r_inst_pc;

    if (w_rsp_accept) begin
      w_inst_valid_nxt = 1'b1;
      w_inst_data_nxt  = imem_rsp_data;
      w_inst_pc_nxt    = r_req_pc;
    end else if (!stall || redirect_valid) begin
      w_inst_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_VEC;
      r_req_pc     <= '0;
      r_inst_valid <= 1'b0;
      r_inst_data  <= '0;
      r_inst_pc    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_req_pc     <= w_req_pc_nxt;
      r_inst_valid <= w_inst_valid_nxt;
      r_inst_data  <= w_inst_data_nxt;
      r_inst_pc    <= w_inst_pc_nxt;
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign inst_valid     = r_inst_valid;
  assign inst_data      = r_inst_data;
  assign inst_pc        = r_inst_pc;
  assign PC             = r_pc;

endmodule
`default_nettype wire
